mutex_arbiter: RTL and testbench

Hardware responder for the Eisenberg-McGuire mutual exclusion protocol. It owns the critical-section resource and serves up to HIPROC+1 requesters over a level req/grant handshake. A rotating `turn` pointer is advanced past each releasing owner, so waiting is bounded and there is no starvation. The block sits between the process models and the shared resource, and it exports owner/busy/turn for property monitors.

---
 rtl/mutex_arbiter_if.sv | 32 +++
 rtl/mutex_arbiter.sv | 158 +++++++++++++++
 tb/tb_mutex_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mutex_arbiter_if.sv
// Request/grant bundle between the Eisenberg-McGuire requesters and the
// mutex_arbiter responder. Requesters drive req; the arbiter drives the
// grant and the observability signals used by property monitors.
interface mutex_arbiter_if #(
    parameter int HIPROC = 2,
    parameter int SELMSB = 1
);
    logic [HIPROC:0] req;
    logic [HIPROC:0] grant;
    logic            busy;
    logic [SELMSB:0] owner;
    logic [SELMSB:0] turn;
    logic            starve;

    modport master (
        output req,
        input  grant,
        input  busy,
        input  owner,
        input  turn,
        input  starve
    );

    modport slave (
        input  req,
        output grant,
        output busy,
        output owner,
        output turn,
        output starve
    );
endinterface

// File: rtl/mutex_arbiter.sv
// mutex_arbiter: hardware responder for the Eisenberg-McGuire mutual
// exclusion protocol. A rotating turn pointer picks where each scan starts,
// one index is examined per cycle, and the owner keeps the grant until it
// drops its request. Optional starvation monitor is built only when the
// macro MUTEX_STARVE_CHK_EN is defined; otherwise starve is constant 0.
module mutex_arbiter #(
    parameter int HIPROC       = 2,
    parameter int SELMSB       = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic            clock,
    input  logic            reset_n,
    mutex_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;

    localparam logic [SELMSB:0] LAST = (SELMSB+1)'(HIPROC);
    localparam logic [SELMSB:0] ONE  = (SELMSB+1)'(1);

    state_t          state, state_next;
    logic [HIPROC:0] req;
    logic [HIPROC:0] grant, grant_next;
    logic            busy, busy_next;
    logic [SELMSB:0] owner, owner_next;
    logic [SELMSB:0] turn, turn_next;
    logic [SELMSB:0] j, j_next;
    logic [SELMSB:0] sweep, sweep_next;
    logic            starve;

    assign req        = bus.req;
    assign bus.grant  = grant;
    assign bus.busy   = busy;
    assign bus.owner  = owner;
    assign bus.turn   = turn;
    assign bus.starve = starve;

    // Cyclic successor of an index; wraps from HIPROC back to 0.
    function automatic logic [SELMSB:0] next_idx(input logic [SELMSB:0] x);
        return (x == LAST) ? '0 : x + ONE;
    endfunction

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decision: start a scan on any request, stop on a hit or a
    // fruitless full sweep, leave GRANT only when the owner releases.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (|req) state_next = SCAN;
            SCAN: begin
                if (req[j])            state_next = GRANT;
                else if (sweep == LAST) state_next = IDLE;
            end
            GRANT: if (!req[owner]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the scan index, grant and turn registers; the release
    // moves turn just past the departing owner so nobody waits unboundedly.
    always_comb begin
        grant_next = grant;
        busy_next  = busy;
        owner_next = owner;
        turn_next  = turn;
        j_next     = j;
        sweep_next = sweep;
        case (state)
            IDLE: begin
                if (|req) begin
                    j_next     = turn;
                    sweep_next = '0;
                end
            end
            SCAN: begin
                if (req[j]) begin
                    grant_next    = '0;
                    grant_next[j] = 1'b1;
                    owner_next    = j;
                    busy_next     = 1'b1;
                end else if (sweep != LAST) begin
                    j_next     = next_idx(j);
                    sweep_next = sweep + ONE;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    grant_next = '0;
                    busy_next  = 1'b0;
                    turn_next  = next_idx(owner);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and scan bookkeeping; reset drops the grant at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant <= '0;
            busy  <= 1'b0;
            owner <= '0;
            turn  <= '0;
            j     <= '0;
            sweep <= '0;
        end else begin
            grant <= grant_next;
            busy  <= busy_next;
            owner <= owner_next;
            turn  <= turn_next;
            j     <= j_next;
            sweep <= sweep_next;
        end
    end

`ifdef MUTEX_STARVE_CHK_EN
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] CNT_SAT = CW'(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LIM = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] wait_cnt  [HIPROC+1];
    logic [CW-1:0] wait_next [HIPROC+1];
    logic          over;
    logic          starve_q;

    // Per-requester wait counters that saturate just past the limit.
    always_comb begin
        over = 1'b0;
        for (int i = 0; i <= HIPROC; i++) begin
            wait_next[i] = wait_cnt[i];
            if (!req[i] || grant[i])       wait_next[i] = '0;
            else if (wait_cnt[i] != CNT_SAT) wait_next[i] = wait_cnt[i] + CNT_ONE;
            if (wait_next[i] > CNT_LIM) over = 1'b1;
        end
    end

    // Counter storage and the sticky starvation flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= HIPROC; i++) wait_cnt[i] <= '0;
            starve_q <= 1'b0;
        end else begin
            for (int i = 0; i <= HIPROC; i++) wait_cnt[i] <= wait_next[i];
            starve_q <= starve_q | over;
        end
    end

    assign starve = starve_q;
`else
    // No monitor built; a negative limit is meaningless, so this is constant 0.
    assign starve = (STARVE_LIMIT < 0);
`endif
endmodule

// File: tb/tb_mutex_arbiter.sv
// Self-checking bench for mutex_arbiter: directed scenarios followed by
// random requester traffic, all compared against a cycle-level reference
// model of the Eisenberg-McGuire responder kept in this file.
module tb_mutex_arbiter;
    localparam int HIPROC = 2;
    localparam int SELMSB = 1;
    localparam int LIMIT  = 3;
    localparam int N      = HIPROC + 1;

    logic clock;
    logic reset_n;

    int vectors;
    int miscompares;

    // Reference model: mode 0 free, 1 searching, 2 held.
    int m_mode;
    int m_turn;
    int m_owner;
    int m_start;
    int m_offset;
    int m_wait [N];
    int m_starve;

    mutex_arbiter_if #(.HIPROC(HIPROC), .SELMSB(SELMSB)) bus ();

    mutex_arbiter #(
        .HIPROC(HIPROC),
        .SELMSB(SELMSB),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int exp_grant();
        return (m_mode == 2) ? (1 << m_owner) : 0;
    endfunction

    function automatic int expect_starve_flag();
`ifdef MUTEX_STARVE_CHK_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_turn   = 0;
        m_owner  = 0;
        m_start  = 0;
        m_offset = 0;
        m_starve = 0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    // One clock of the protocol rules applied to the sampled request vector.
    task automatic model_step(input logic [2:0] r);
        int g;
        int idx;
        g = exp_grant();
`ifdef MUTEX_STARVE_CHK_EN
        for (int i = 0; i < N; i++) begin
            if (r[i] && !g[i]) m_wait[i] = (m_wait[i] >= LIMIT + 1) ? LIMIT + 1 : m_wait[i] + 1;
            else               m_wait[i] = 0;
            if (m_wait[i] > LIMIT) m_starve = 1;
        end
`endif
        case (m_mode)
            0: if (r != 0) begin
                m_mode   = 1;
                m_start  = m_turn;
                m_offset = 0;
            end
            1: begin
                idx = (m_start + m_offset) % N;
                if (r[idx]) begin
                    m_mode  = 2;
                    m_owner = idx;
                end else if (m_offset == N - 1) begin
                    m_mode = 0;
                end else begin
                    m_offset++;
                end
            end
            default: if (!r[m_owner]) begin
                m_mode = 0;
                m_turn = (m_owner + 1) % N;
            end
        endcase
    endtask

    task automatic compare_all();
        check_output("grant",  32'(bus.grant), 32'(exp_grant()));
        check_output("busy",   32'(bus.busy), 32'(m_mode == 2));
        check_output("owner",  32'(bus.owner), 32'(m_owner));
        check_output("turn",   32'(bus.turn), 32'(m_turn));
        check_output("starve", 32'(bus.starve), 32'(m_starve));
        check_output("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
    endtask

    // Drive one request vector for one clock, advance the model, then check.
    task automatic apply_stimulus(input logic [2:0] r);
        bus.req = r;
        @(posedge clock);
        model_step(r);
        @(negedge clock);
        compare_all();
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic do_reset();
        bus.req = '0;
        reset_n = 1'b0;
        #1;
        check_output("rst_grant", 32'(bus.grant), 32'd0);
        check_output("rst_busy",  32'(bus.busy), 32'd0);
        check_output("rst_turn",  32'(bus.turn), 32'd0);
        check_output("rst_owner", 32'(bus.owner), 32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        compare_all();
    endtask

    initial begin
        logic [2:0] r;
        int hold [N];
        int held;
        int exp_next;
        bit was_held;

        vectors     = 0;
        miscompares = 0;
        bus.req     = '0;
        reset_n     = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        compare_all();

        $display("[TB] single requester");
        repeat (3) apply_stimulus(3'b010);
        check_output("single_grant", 32'(bus.grant), 32'b010);
        check_output("single_owner", 32'(bus.owner), 32'd1);
        repeat (2) apply_stimulus(3'b010);
        apply_stimulus(3'b000);
        check_output("single_release", 32'(bus.grant), 32'd0);
        check_output("single_turn", 32'(bus.turn), 32'd2);

        $display("[TB] all requesting, rotating");
        do_reset();
        held     = 0;
        exp_next = 0;
        for (int c = 0; c < 60; c++) begin
            r = 3'b111;
            if (m_mode == 2) begin
                if (held == 4) r[m_owner] = 1'b0;
                else           held++;
            end
            was_held = (m_mode == 2);
            apply_stimulus(r);
            if (m_mode == 2 && !was_held) begin
                check_output("order", 32'(bus.owner), 32'(exp_next));
                exp_next = (exp_next + 1) % N;
                held = 0;
            end
        end

        $display("[TB] withdrawal during scan");
        do_reset();
        apply_stimulus(3'b100);
        apply_stimulus(3'b100);
        repeat (4) apply_stimulus(3'b000);
        check_output("withdraw_grant", 32'(bus.grant), 32'd0);
        check_output("withdraw_turn", 32'(bus.turn), 32'd0);

        $display("[TB] release with simultaneous request");
        do_reset();
        repeat (5) apply_stimulus(3'b100);
        check_output("owner2", 32'(bus.owner), 32'd2);
        apply_stimulus(3'b001);
        check_output("wrap_turn", 32'(bus.turn), 32'd0);
        apply_stimulus(3'b001);
        check_output("gap_grant", 32'(bus.grant), 32'd0);
        apply_stimulus(3'b001);
        check_output("next_grant", 32'(bus.grant), 32'b001);

        $display("[TB] reset during grant");
        do_reset();

        $display("[TB] starvation monitor");
        repeat (11) apply_stimulus(3'b011);
        check_output("starve_set", 32'(bus.starve), 32'(expect_starve_flag()));
        repeat (4) apply_stimulus(3'b010);
        check_output("starve_grant1", 32'(bus.grant), 32'b010);
        check_output("starve_sticky", 32'(bus.starve), 32'(expect_starve_flag()));

        $display("[TB] random traffic");
        do_reset();
        r = '0;
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    if (exp_grant() & (1 << i)) begin
                        if (hold[i] == 0) r[i] = 1'b0;
                        else              hold[i]--;
                    end else if ($urandom_range(0, 15) == 0) begin
                        r[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    r[i]    = 1'b1;
                    hold[i] = int'($urandom_range(0, 6));
                end
            end
            apply_stimulus(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
